seq_restoring_divider: RTL and testbench

//  Iterative unsigned restoring divider, the inverse of the team's Vedic multipliers.

---
 rtl/seq_restoring_divider.sv | 127 ++++++++++++
 tb/tb_seq_restoring_divider.sv | 219 +++++++++++++++++++++
 2 files changed

// File: rtl/seq_restoring_divider.sv
// Iterative unsigned restoring divider: one quotient bit per clock, MSB first, start/done handshake.
// state | meaning:  IDLE | waiting for start,  CALC | shift/compare/subtract step,  DONE | results valid, done=1
module seq_restoring_divider #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder,
    output logic             div_by_zero
);

    localparam int CW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t           state_q, state_d;
    logic [WIDTH-1:0] dvd_q, dvd_d;
    logic [WIDTH-1:0] dsr_q, dsr_d;
    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [CW-1:0]    cnt_q, cnt_d;
    logic [WIDTH-1:0] quotient_q, quotient_d;
    logic [WIDTH-1:0] remainder_q, remainder_d;
    logic             dbz_q, dbz_d;

    // The stored partial remainder is always < divisor, so WIDTH bits hold it;
    // only the shifted trial value needs the extra bit for an overflow-free compare.
    logic [WIDTH:0]   r_shift;
    logic [WIDTH-1:0] r_sub;
    logic             q_bit;

    always_comb begin
        state_d     = state_q;
        dvd_d       = dvd_q;
        dsr_d       = dsr_q;
        rem_d       = rem_q;
        quo_d       = quo_q;
        cnt_d       = cnt_q;
        quotient_d  = quotient_q;
        remainder_d = remainder_q;
        dbz_d       = dbz_q;

        r_shift = {rem_q, dvd_q[WIDTH-1]};
        q_bit   = (r_shift >= {1'b0, dsr_q});
        r_sub   = r_shift[WIDTH-1:0] - dsr_q;

        case (state_q)
            S_IDLE: begin
                if (start) begin
                    dvd_d = dividend;
                    dsr_d = divisor;
                    rem_d = '0;
                    quo_d = '0;
                    cnt_d = '0;
                    if (divisor == '0) begin
                        state_d     = S_DONE;
                        quotient_d  = '1;
                        remainder_d = dividend;
                        dbz_d       = 1'b1;
                    end else begin
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                dvd_d = {dvd_q[WIDTH-2:0], 1'b0};
                rem_d = q_bit ? r_sub : r_shift[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], q_bit};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == LAST_STEP) begin
                    state_d     = S_DONE;
                    quotient_d  = quo_d;
                    remainder_d = rem_d;
                    dbz_d       = 1'b0;
                end
            end
            S_DONE: begin
                state_d = S_IDLE;
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= S_IDLE;
            dvd_q       <= '0;
            dsr_q       <= '0;
            rem_q       <= '0;
            quo_q       <= '0;
            cnt_q       <= '0;
            quotient_q  <= '0;
            remainder_q <= '0;
            dbz_q       <= 1'b0;
        end else begin
            state_q     <= state_d;
            dvd_q       <= dvd_d;
            dsr_q       <= dsr_d;
            rem_q       <= rem_d;
            quo_q       <= quo_d;
            cnt_q       <= cnt_d;
            quotient_q  <= quotient_d;
            remainder_q <= remainder_d;
            dbz_q       <= dbz_d;
        end
    end

    assign busy        = (state_q != S_IDLE);
    assign done        = (state_q == S_DONE);
    assign quotient    = quotient_q;
    assign remainder   = remainder_q;
    assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_seq_restoring_divider.sv
// Randomized and directed checks of seq_restoring_divider at WIDTH=4 and WIDTH=8 against an arithmetic model.
module tb_seq_restoring_divider;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       start4 = 1'b0, start8 = 1'b0;
    logic [3:0] a4 = '0, d4 = '0;
    logic [7:0] a8 = '0, d8 = '0;
    logic       busy4, done4, dbz4, busy8, done8, dbz8;
    logic [3:0] q4, r4;
    logic [7:0] q8, r8;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    seq_restoring_divider #(.WIDTH(4)) u_dut4 (
        .clk(clk), .rst_n(rst_n), .start(start4), .dividend(a4), .divisor(d4),
        .busy(busy4), .done(done4), .quotient(q4), .remainder(r4), .div_by_zero(dbz4)
    );

    seq_restoring_divider #(.WIDTH(8)) u_dut8 (
        .clk(clk), .rst_n(rst_n), .start(start8), .dividend(a8), .divisor(d8),
        .busy(busy8), .done(done8), .quotient(q8), .remainder(r8), .div_by_zero(dbz8)
    );

    task automatic check(input string tag, input int got, input int exp);
        n_cmp++;
        if (got != exp) begin
            n_err++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    function automatic int obs_done(input int w); return (w == 4) ? int'(done4) : int'(done8); endfunction
    function automatic int obs_busy(input int w); return (w == 4) ? int'(busy4) : int'(busy8); endfunction
    function automatic int obs_q(input int w);    return (w == 4) ? int'(q4)    : int'(q8);    endfunction
    function automatic int obs_r(input int w);    return (w == 4) ? int'(r4)    : int'(r8);    endfunction
    function automatic int obs_dbz(input int w);  return (w == 4) ? int'(dbz4)  : int'(dbz8);  endfunction

    task automatic drive(input int w, input bit s, input int a, input int d);
        if (w == 4) begin
            start4 = s; a4 = 4'(a); d4 = 4'(d);
        end else begin
            start8 = s; a8 = 8'(a); d8 = 8'(d);
        end
    endtask

    task automatic drop_start(input int w);
        if (w == 4) start4 = 1'b0;
        else        start8 = 1'b0;
    endtask

    // One full transaction: model result, latency, busy, hold-before-done and single-pulse checks.
    task automatic run_op(input int w, input int a, input int d, input string tag);
        int  exp_q, exp_r, exp_dbz, exp_lat, prev_q, prev_r, k;
        bit  seen;
        if (d == 0) begin
            exp_q = (1 << w) - 1; exp_r = a; exp_dbz = 1; exp_lat = 1;
        end else begin
            exp_q = a / d; exp_r = a % d; exp_dbz = 0; exp_lat = w + 1;
        end
        @(negedge clk);
        prev_q = obs_q(w);
        prev_r = obs_r(w);
        drive(w, 1'b1, a, d);
        @(posedge clk);
        seen = 1'b0;
        k = 0;
        while (!seen && k < 40) begin
            @(negedge clk);
            k++;
            if (obs_done(w) == 1) begin
                seen = 1'b1;
            end else if (k == 1) begin
                check({tag, "_busy"}, obs_busy(w), 1);
                check({tag, "_hold_q"}, obs_q(w), prev_q);
                check({tag, "_hold_r"}, obs_r(w), prev_r);
            end
            if (k == 1) drop_start(w);
        end
        if (!seen) begin
            check({tag, "_timeout"}, 0, 1);
        end else begin
            check({tag, "_lat"}, k, exp_lat);
            check({tag, "_q"}, obs_q(w), exp_q);
            check({tag, "_r"}, obs_r(w), exp_r);
            check({tag, "_dbz"}, obs_dbz(w), exp_dbz);
            check({tag, "_busy_done"}, obs_busy(w), 1);
        end
        @(negedge clk);
        check({tag, "_pulse"}, obs_done(w), 0);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int k, ndone, first_k, second_k, sq, sr;
        int a, d;

        repeat (3) @(negedge clk);
        check("rst_busy", busy4, 0);
        check("rst_done", done4, 0);
        check("rst_q", q4, 0);
        check("rst_r", r4, 0);
        check("rst_dbz", dbz4, 0);
        check("rst_q8", q8, 0);
        rst_n = 1'b1;
        @(negedge clk);

        run_op(4, 9, 2, "t1_9_2");

        run_op(4, 15, 15, "t2_15_15");
        repeat (3) @(negedge clk);
        check("t2_keep_q", q4, 1);
        check("t2_keep_r", r4, 0);
        run_op(4, 0, 3, "t2_0_3");
        run_op(4, 5, 7, "t2_5_7");
        repeat (2) @(negedge clk);
        check("t2_keep_r2", r4, 5);

        run_op(4, 7, 0, "t3_7_0");
        run_op(4, 6, 3, "t3_6_3");

        // start pulse with new operands while CALC is running
        @(negedge clk);
        drive(4, 1'b1, 14, 3);
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        drive(4, 1'b1, 12, 5);
        @(negedge clk);
        start4 = 1'b0;
        ndone = 0; first_k = 0; sq = 0; sr = 0;
        for (int kk = 4; kk <= 18; kk++) begin
            @(negedge clk);
            if (done4) begin
                ndone++;
                if (ndone == 1) begin first_k = kk; sq = q4; sr = r4; end
            end
        end
        check("t4_ndone", ndone, 1);
        check("t4_lat", first_k, 5);
        check("t4_q", sq, 4);
        check("t4_r", sr, 2);

        // start held high across DONE: re-accepted only at the following IDLE edge
        @(negedge clk);
        drive(4, 1'b1, 10, 3);
        @(posedge clk);
        ndone = 0; first_k = 0; second_k = 0;
        for (int kk = 1; kk <= 14; kk++) begin
            @(negedge clk);
            if (done4) begin
                ndone++;
                if (ndone == 1) first_k = kk;
                if (ndone == 2) second_k = kk;
            end
        end
        start4 = 1'b0;
        check("held_ndone", ndone, 2);
        check("held_first", first_k, 5);
        check("held_second", second_k, 11);
        k = 0;
        while (busy4 && k < 20) begin @(negedge clk); k++; end
        check("held_idle", busy4, 0);

        // reset mid-operation
        run_op(4, 11, 2, "t5_pre");
        @(negedge clk);
        drive(4, 1'b1, 13, 4);
        @(posedge clk);
        @(negedge clk);
        start4 = 1'b0;
        @(negedge clk);
        rst_n = 1'b0;
        #1;
        check("t5_busy", busy4, 0);
        check("t5_done", done4, 0);
        check("t5_q", q4, 0);
        check("t5_r", r4, 0);
        check("t5_dbz", dbz4, 0);
        @(negedge clk);
        rst_n = 1'b1;
        ndone = 0; k = 0;
        repeat (8) begin
            @(negedge clk);
            if (done4) ndone++;
            if (busy4) k++;
        end
        check("t5_no_done", ndone, 0);
        check("t5_stay_idle", k, 0);
        run_op(4, 13, 4, "t5_13_4");

        for (int i = 0; i < 16; i++)
            for (int j = 0; j < 16; j++)
                run_op(4, i, j, "sweep4");

        for (int n = 0; n < 250; n++) begin
            a = int'($urandom_range(255, 0));
            d = ($urandom_range(15, 0) == 0) ? 0 : int'($urandom_range(255, 1));
            run_op(8, a, d, "rand8");
        end
        run_op(8, 255, 1, "b8_255_1");
        run_op(8, 255, 255, "b8_255_255");
        run_op(8, 200, 0, "b8_200_0");
        run_op(8, 3, 200, "b8_3_200");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
